dehaze_transmittance_est: RTL and testbench

// Per-pixel DCP transmittance estimator, parametrised successor of the fixed 8-bit dark-max/transmittance stage.

---
 rtl/dehaze_transmittance_est_if.sv | 13 +
 rtl/dehaze_transmittance_est.sv | 148 ++++++++++++++
 tb/tb_dehaze_transmittance_est.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dehaze_transmittance_est_if.sv
// Pixel stream bundle (dark channel plus syncs) between dehaze stages.
// The master drives the stream and the slave consumes it.
interface dehaze_transmittance_est_if #(
  parameter int DW = 8
) ();
  logic [DW-1:0] dark;
  logic          hsync;
  logic          vsync;
  logic          de;

  modport master (output dark, hsync, vsync, de);
  modport slave  (input  dark, hsync, vsync, de);
endinterface

// File: rtl/dehaze_transmittance_est.sv
// DCP transmittance estimator: per-frame atmospheric light and omega,
// then t = FS - omega*dark with a floor, in a 3-cycle pipeline.
module dehaze_transmittance_est #(
  parameter int DW          = 8,
  parameter int T0          = 26,
  parameter int OMEGA_MAX   = 256,
  parameter int OMEGA_MIN   = 164,
  parameter int A_KNEE      = 160,
  parameter int SLOPE_SHIFT = 1
) (
  input  logic                  pixelclk,
  input  logic                  reset,
  dehaze_transmittance_est_if.slave  i_px,
  dehaze_transmittance_est_if.master o_px,
  input  logic                  i_freeze,
  output logic [DW-1:0]         o_dark_max,
  output logic [8:0]            o_omega,
  output logic                  o_a_valid,
  output logic [DW-1:0]         o_transmittance
);

  localparam int            WW   = DW + 10;
  localparam logic [DW-1:0] FS   = '1;
  localparam logic [DW-1:0] T0_V = DW'(T0);
  localparam logic [DW-1:0] KNEE = DW'(A_KNEE);

  typedef enum logic [1:0] {
    WAIT_VS,
    FIRST,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          latch;
  logic          vsync_d;
  logic          vs_rise;
  logic [DW-1:0] acc_max;
  logic [8:0]    omega_q;
  logic [DW-1:0] a_excess;
  logic [WW-1:0] drop_w;
  logic [8:0]    omega_new;

  assign vs_rise = i_px.vsync & ~vsync_d;

  assign a_excess = (acc_max > KNEE) ? acc_max - KNEE : '0;
  assign drop_w   = WW'(a_excess >> SLOPE_SHIFT);
  assign omega_new =
    (drop_w > WW'(OMEGA_MAX - OMEGA_MIN)) ? 9'(OMEGA_MIN)
                                          : 9'(WW'(OMEGA_MAX) - drop_w);

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      WAIT_VS: begin
        if (vs_rise) state_d = FIRST;
      end
      FIRST: begin
        if (vs_rise && !i_freeze) begin
          state_d = RUN;
          latch   = 1'b1;
        end
      end
      RUN: begin
        if (vs_rise && !i_freeze) latch = 1'b1;
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_q    <= WAIT_VS;
      vsync_d    <= 1'b0;
      acc_max    <= '0;
      omega_q    <= 9'(OMEGA_MAX);
      o_dark_max <= '0;
      o_omega    <= '0;
      o_a_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_d <= i_px.vsync;
      // The boundary pixel seeds the new frame, not the latched one.
      if (vs_rise)
        acc_max <= i_px.de ? i_px.dark : '0;
      else if (i_px.de && i_px.dark > acc_max)
        acc_max <= i_px.dark;
      if (latch) begin
        o_dark_max <= acc_max;
        omega_q    <= omega_new;
        o_omega    <= omega_new;
        o_a_valid  <= 1'b1;
      end
    end
  end

  logic [DW-1:0] s1_dark;
  logic          s1_hs, s1_vs, s1_de;
  logic [DW-1:0] s2_dark;
  logic [DW-1:0] s2_ph;
  logic          s2_hs, s2_vs, s2_de;
  logic [DW+8:0] prod_c;
  logic [DW-1:0] tr_c;
  logic [DW-1:0] t_c;

  assign prod_c = (DW+9)'(omega_q) * (DW+9)'(s1_dark);
  assign tr_c   = FS - s2_ph;
  assign t_c    = (tr_c < T0_V) ? T0_V : tr_c;

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      s1_dark         <= '0;
      s1_hs           <= 1'b0;
      s1_vs           <= 1'b0;
      s1_de           <= 1'b0;
      s2_dark         <= '0;
      s2_ph           <= '0;
      s2_hs           <= 1'b0;
      s2_vs           <= 1'b0;
      s2_de           <= 1'b0;
      o_px.dark       <= '0;
      o_px.hsync      <= 1'b0;
      o_px.vsync      <= 1'b0;
      o_px.de         <= 1'b0;
      o_transmittance <= '0;
    end else begin
      s1_dark    <= i_px.dark;
      s1_hs      <= i_px.hsync;
      s1_vs      <= i_px.vsync;
      s1_de      <= i_px.de;
      s2_dark    <= s1_dark;
      s2_ph      <= DW'(prod_c >> 8);
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_de      <= s1_de;
      o_px.dark  <= s2_dark;
      o_px.hsync <= s2_hs;
      o_px.vsync <= s2_vs;
      o_px.de    <= s2_de;
      // Until A is known the stage is transparent: no haze removal.
      if (!s2_de)          o_transmittance <= '0;
      else if (!o_a_valid) o_transmittance <= FS;
      else                 o_transmittance <= t_c;
    end
  end

endmodule

// File: tb/tb_dehaze_transmittance_est.sv
// Directed bench for dehaze_transmittance_est: three builds share one
// input stream (default, steep knee for clamping, flat omega=1.0).
module tb_dehaze_transmittance_est;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frz = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dehaze_transmittance_est_if #(.DW(8)) in_if ();
  dehaze_transmittance_est_if #(.DW(8)) o1 ();
  dehaze_transmittance_est_if #(.DW(8)) o2 ();
  dehaze_transmittance_est_if #(.DW(8)) o3 ();

  logic [7:0] a1, a2, a3, t1, t2, t3;
  logic [8:0] w1, w2, w3;
  logic       v1, v2, v3;

  dehaze_transmittance_est dut1 (
    .pixelclk(clk), .reset(rst), .i_px(in_if), .o_px(o1),
    .i_freeze(frz), .o_dark_max(a1), .o_omega(w1),
    .o_a_valid(v1), .o_transmittance(t1)
  );

  dehaze_transmittance_est #(.A_KNEE(0), .SLOPE_SHIFT(0)) dut2 (
    .pixelclk(clk), .reset(rst), .i_px(in_if), .o_px(o2),
    .i_freeze(frz), .o_dark_max(a2), .o_omega(w2),
    .o_a_valid(v2), .o_transmittance(t2)
  );

  dehaze_transmittance_est #(.A_KNEE(255)) dut3 (
    .pixelclk(clk), .reset(rst), .i_px(in_if), .o_px(o3),
    .i_freeze(frz), .o_dark_max(a3), .o_omega(w3),
    .o_a_valid(v3), .o_transmittance(t3)
  );

  logic [7:0] hd [3];
  logic       hh [3];
  logic       hv [3];
  logic       hde [3];

  task automatic step(input logic [7:0] d, input logic h,
                      input logic v, input logic de);
    in_if.dark  = d;
    in_if.hsync = h;
    in_if.vsync = v;
    in_if.de    = de;
    for (int k = 2; k > 0; k--) begin
      hd[k] = hd[k-1]; hh[k] = hh[k-1];
      hv[k] = hv[k-1]; hde[k] = hde[k-1];
    end
    hd[0] = d; hh[0] = h; hv[0] = v; hde[0] = de;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (a1 !== 8'd0) begin
      fails++; $display("FAIL rst_a: got %0d want 0", a1);
    end
    tests++;
    if (w1 !== 9'd0) begin
      fails++; $display("FAIL rst_omega: got %0d want 0", w1);
    end
    tests++;
    if (v1 !== 1'b0) begin
      fails++; $display("FAIL rst_valid: got %0b want 0", v1);
    end
    tests++;
    if ({t1, o1.dark, o1.hsync, o1.vsync, o1.de} !== 19'd0) begin
      fails++;
      $display("FAIL rst_pipe: got t=%0d d=%0d de=%0b want 0",
               t1, o1.dark, o1.de);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)      step(8'd0, 1'b0, 1'b1, 1'b0);
      else if (i < 18) begin
        d = (i == 7) ? 8'd200 : 8'd100;
        step(d, ((i - 2) % 4) == 0, 1'b0, i >= 2);
      end else         step(8'd0, 1'b0, 1'b0, 1'b0);
      tests++;
      if ({o1.dark, o1.hsync, o1.vsync, o1.de} !==
          {hd[2], hh[2], hv[2], hde[2]}) begin
        fails++;
        $display("FAIL delay[%0d]: got d=%0d h%0b v%0b de%0b want d=%0d h%0b v%0b de%0b",
                 i, o1.dark, o1.hsync, o1.vsync, o1.de,
                 hd[2], hh[2], hv[2], hde[2]);
      end
      tests++;
      if (t1 !== (hde[2] ? 8'd255 : 8'd0)) begin
        fails++;
        $display("FAIL bypass_t[%0d]: got %0d want %0d",
                 i, t1, hde[2] ? 255 : 0);
      end
    end
    tests++;
    if (v1 !== 1'b0 || a1 !== 8'd0) begin
      fails++; $display("FAIL first_valid: got v=%0b a=%0d want 0 0", v1, a1);
    end
  endtask

  task automatic test_estimate();
    logic [7:0] px [5] = '{8'd100, 8'd0, 8'd200, 8'd250, 8'd240};
    logic [7:0] e1 [5] = '{8'd163, 8'd255, 8'd71, 8'd26, 8'd34};
    logic [7:0] e3 [5] = '{8'd155, 8'd255, 8'd55, 8'd26, 8'd26};
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({v1, a1, w1} !== {1'b1, 8'd200, 9'd236}) begin
      fails++;
      $display("FAIL est_latch: got v=%0b a=%0d w=%0d want 1 200 236", v1, a1, w1);
    end
    tests++;
    if (w2 !== 9'd164 || w3 !== 9'd256) begin
      fails++;
      $display("FAIL est_omega23: got %0d %0d want 164 256", w2, w3);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(px[i], 1'b0, 1'b0, 1'b1);
      else       step(8'd0, 1'b0, 1'b0, 1'b0);
      if (i >= 2) begin
        tests++;
        if (t1 !== e1[i-2] || t3 !== e3[i-2]) begin
          fails++;
          $display("FAIL est_t[%0d]: got %0d/%0d want %0d/%0d",
                   i - 2, t1, t3, e1[i-2], e3[i-2]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] px [3] = '{8'd255, 8'd240, 8'd0};
    logic [7:0] e1 [3] = '{8'd45, 8'd58, 8'd255};
    logic [7:0] e2 [3] = '{8'd92, 8'd102, 8'd255};
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({a1, w1, a2, w2} !== {8'd250, 9'd211, 8'd250, 9'd164}) begin
      fails++;
      $display("FAIL clamp_latch: got a=%0d w=%0d a2=%0d w2=%0d want 250 211 250 164",
               a1, w1, a2, w2);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(px[i], 1'b0, 1'b0, 1'b1);
      else       step(8'd0, 1'b0, 1'b0, 1'b0);
      if (i >= 2) begin
        tests++;
        if (t1 !== e1[i-2] || t2 !== e2[i-2]) begin
          fails++;
          $display("FAIL clamp_t[%0d]: got %0d/%0d want %0d/%0d",
                   i - 2, t1, t2, e1[i-2], e2[i-2]);
        end
      end
    end
  endtask

  task automatic test_floor();
    logic [7:0] px [3] = '{8'd255, 8'd0, 8'd255};
    logic       de [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] e3 [3] = '{8'd26, 8'd255, 8'd0};
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({a3, w3, w1} !== {8'd255, 9'd256, 9'd209}) begin
      fails++;
      $display("FAIL floor_latch: got a3=%0d w3=%0d w1=%0d want 255 256 209",
               a3, w3, w1);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(px[i], 1'b0, 1'b0, de[i]);
      else       step(8'd0, 1'b0, 1'b0, 1'b0);
      if (i >= 2) begin
        tests++;
        if (t3 !== e3[i-2]) begin
          fails++;
          $display("FAIL floor_t[%0d]: got %0d want %0d", i - 2, t3, e3[i-2]);
        end
      end
    end
    tests++;
    if (t1 !== 8'd0) begin
      fails++; $display("FAIL floor_de0: got %0d want 0", t1);
    end
  endtask

  task automatic test_freeze();
    step(8'd0, 1'b0, 1'b1, 1'b0);
    step(8'd180, 1'b0, 1'b0, 1'b1);
    step(8'd50, 1'b0, 1'b0, 1'b1);
    frz = 1'b1;
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({a1, w1} !== {8'd255, 9'd209}) begin
      fails++;
      $display("FAIL freeze_hold: got a=%0d w=%0d want 255 209", a1, w1);
    end
    frz = 1'b0;
    step(8'd120, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (t1 !== 8'd158) begin
      fails++; $display("FAIL freeze_t: got %0d want 158", t1);
    end
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({a1, w1} !== {8'd120, 9'd256}) begin
      fails++;
      $display("FAIL freeze_release: got a=%0d w=%0d want 120 256", a1, w1);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(8'd90, 1'b0, 1'b0, 1'b1);
    step(8'd77, 1'b0, 1'b1, 1'b1);
    tests++;
    if (a1 !== 8'd90) begin
      fails++; $display("FAIL b2b_first: got %0d want 90", a1);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({a1, w1} !== {8'd77, 9'd256}) begin
      fails++;
      $display("FAIL b2b_second: got a=%0d w=%0d want 77 256", a1, w1);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(8'd200, 1'b0, 1'b0, 1'b1);
    step(8'd200, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step(8'd200, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tests++;
    if ({t1, o1.dark, o1.de, a1, w1, v1} !== 35'd0) begin
      fails++;
      $display("FAIL midrst: got t=%0d d=%0d de=%0b a=%0d w=%0d v=%0b want 0",
               t1, o1.dark, o1.de, a1, w1, v1);
    end
    step(8'd100, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    step(8'd0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (t1 !== 8'd255) begin
      fails++; $display("FAIL midrst_bypass: got %0d want 255", t1);
    end
    step(8'd0, 1'b0, 1'b1, 1'b0);
    step(8'd60, 1'b0, 1'b0, 1'b1);
    frz = 1'b1;
    step(8'd0, 1'b0, 1'b1, 1'b0);
    frz = 1'b0;
    tests++;
    if (v1 !== 1'b0) begin
      fails++; $display("FAIL midrst_frozen_first: got v=%0b want 0", v1);
    end
    step(8'd70, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({v1, a1, w1} !== {1'b1, 8'd70, 9'd256}) begin
      fails++;
      $display("FAIL midrst_revalid: got v=%0b a=%0d w=%0d want 1 70 256",
               v1, a1, w1);
    end
    step(8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      hd[k] = '0; hh[k] = 1'b0; hv[k] = 1'b0; hde[k] = 1'b0;
    end
    in_if.dark  = '0;
    in_if.hsync = 1'b0;
    in_if.vsync = 1'b0;
    in_if.de    = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_estimate();
    test_clamp();
    test_floor();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
